// File: rtl/addsub_arbiter.sv
// Round-robin front end for the shared 4-bit adder/subtractor: two valid/ready
// requesters, one tagged response port. Define ADDSUB_ARB_OVF_EN to add rsp_ovf.
module addsub_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_sub,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_sub,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_cin,
  input  logic [WIDTH-1:0] add_s,
  input  logic             add_cout,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_s,
  output logic             rsp_cout,
`ifdef ADDSUB_ARB_OVF_EN
  output logic             rsp_ovf,
`endif
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t state;
  logic   prio;      // requester that wins when both are valid
  logic   grant_any;
  logic   grant_id;

  always_comb begin
    grant_any = 1'b0;
    grant_id  = prio;
    if (state == IDLE && !rst) begin
      if (req0_valid && req1_valid) begin
        grant_any = 1'b1;
        grant_id  = prio;
      end else if (req0_valid) begin
        grant_any = 1'b1;
        grant_id  = 1'b0;
      end else if (req1_valid) begin
        grant_any = 1'b1;
        grant_id  = 1'b1;
      end
    end
  end

  assign req0_ready = grant_any & ~grant_id;
  assign req1_ready = grant_any &  grant_id;
  assign busy       = (state != IDLE);

`ifdef ADDSUB_ARB_OVF_EN
  // Subtract flips B's sign bit, so one rule covers both operations.
  logic ovf_now;
  assign ovf_now = (add_a[WIDTH-1] == (add_b[WIDTH-1] ^ add_cin)) &&
                   (add_s[WIDTH-1] != add_a[WIDTH-1]);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      prio      <= 1'b0;
      add_a     <= '0;
      add_b     <= '0;
      add_cin   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_s     <= '0;
      rsp_cout  <= 1'b0;
`ifdef ADDSUB_ARB_OVF_EN
      rsp_ovf   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            add_a   <= grant_id ? req1_a   : req0_a;
            add_b   <= grant_id ? req1_b   : req0_b;
            add_cin <= grant_id ? req1_sub : req0_sub;
            rsp_id  <= grant_id;
            state   <= EXEC;
          end
        end
        EXEC: begin
          rsp_s     <= add_s;
          rsp_cout  <= add_cout;
`ifdef ADDSUB_ARB_OVF_EN
          rsp_ovf   <= ovf_now;
`endif
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            prio      <= ~rsp_id;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/addsub_arbiter.md
# addsub_arbiter

Two-requester round-robin scheduler that shares one four_bit_adder_sub instance in the 4-bit ALU datapath. Accepts add or subtract requests on two valid/ready ports and drives the shared adder's A/B/Cin from registered operands. Captures S/Cout and returns them on one response port tagged with the requester ID. Sits between the ALU front-end decoders and the single adder/subtractor cell.

## Interface
Parameters:
- WIDTH, 4, operand and result width; must match the shared adder.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_a, req0_b  in  WIDTH  requester 0 operands
- req0_sub  in  1  requester 0 op: 0 = A+B, 1 = A−B
- req1_valid, req1_ready, req1_a, req1_b, req1_sub  as above, requester 1
- add_a, add_b  out  WIDTH  to shared adder A/B (registered)
- add_cin  out  1  to shared adder Cin; equals the latched sub flag
- add_s  in  WIDTH  from shared adder S
- add_cout  in  1  from shared adder Cout
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_id  out  1  requester that owns the result
- rsp_s  out  WIDTH  result
- rsp_cout  out  1  carry out; for subtract, 1 = no borrow
- busy  out  1  high whenever state ≠ IDLE

## Operation
- Shared adder computes S = A + (B xor {WIDTH{Cin}}) + Cin combinationally. Cin = 1 selects subtract.
- FSM states: IDLE, EXEC, RESP.
- IDLE: if any reqN_valid, grant one requester and assert its reqN_ready combinationally. Latch a, b, sub into add_a/add_b/add_cin and the ID into rsp_id. Go to EXEC. If no valid, stay.
- EXEC: operands are stable at the adder for one full cycle. At the clock edge, capture add_s → rsp_s and add_cout → rsp_cout. Go to RESP.
- RESP: hold rsp_valid = 1 with rsp_id/rsp_s/rsp_cout stable until rsp_ready. On the handshake, update the round-robin pointer to the served ID and go to IDLE.
- Round-robin arbitration: the requester not served last has priority. After reset, requester 0 has priority. A lone valid requester is always granted.
- At most one reqN_ready is high in any cycle. reqN_ready is never high outside IDLE.
- Operands not granted must be held by the requester; the block does not buffer them.
- All arithmetic is modulo 2^WIDTH. No saturation.

## Timing
- Reset: state IDLE, add_a = add_b = 0, add_cin = 0, rsp_valid = 0, rsp_id = 0, rsp_s = 0, rsp_cout = 0, busy = 0, pointer prefers req0. reqN_ready is forced 0 while rst = 1.
- Accept at cycle N (valid & ready), capture at end of cycle N+1, rsp_valid high from cycle N+2.
- Minimum initiation interval is 3 cycles per operation (IDLE → EXEC → RESP → IDLE).
- rsp_ready held high: RESP lasts exactly 1 cycle. Backpressure extends RESP indefinitely; the adder inputs and response are held.
- A request arriving during EXEC/RESP waits; it is granted in the next IDLE cycle.
- Simultaneous valid from both requesters: grant goes per pointer. The other requester is served next, ahead of any new request from the just-served requester.
- Reset asserted in any state: the in-flight operation is dropped and the reset values apply on the next edge.

## Configuration
- ADDSUB_ARB_OVF_EN defined: adds output rsp_ovf (1 bit, reset 0), registered alongside rsp_s in EXEC. It is the two's-complement signed overflow:
  - add: a[MSB] == b[MSB] and s[MSB] ≠ a[MSB]
  - sub: a[MSB] ≠ b[MSB] and s[MSB] ≠ a[MSB]
- Undefined: the rsp_ovf port and its logic are absent. All other behaviour is identical.

## Test plan
- req0 add a=0010, b=0011, rsp_ready=1 -> rsp_valid two cycles after accept, rsp_id=0, rsp_s=0101, rsp_cout=0.
- req1 sub a=1101, b=0010 -> add_cin=1 during EXEC; rsp_id=1, rsp_s=1011, rsp_cout=1.
- Both valid from reset and held (req0: 0110+1010, req1: 1111+1111) -> req0 served first (s=0000, cout=1), then req1 (s=1110, cout=1). Never two ready in one cycle.
- rsp_ready held low 5 cycles in RESP with 0101+0011 -> rsp_s=1000 and rsp_valid stay constant, no reqN_ready; releases on cycle 6.
- rst pulsed during EXEC -> next cycle all outputs at reset values, state IDLE; the dropped op never appears on rsp.
- With ADDSUB_ARB_OVF_EN: 0111+0001 -> rsp_s=1000, rsp_ovf=1; 1000−0001 -> rsp_s=0111, rsp_ovf=1; 0010+0011 -> rsp_ovf=0.
